fill_arbiter_rr: RTL and testbench
==================================

Name: fill_arbiter_rr

Overview:
- N-way arbiter that merges fill/miss requests into the single Fill FIFO write port.
- Generalises the two-source alternating arbiter in three ways:
  - NUM_REQ requesters;
  - round-robin or fixed-priority mode;
  - a true valid/ready handshake with a one-entry output register, giving one write per cycle back-to-back.
- Sits between the Tag Comparator / RMiss Handler / future requesters and the Fill FIFO.

Parameters:
- ADDR_WIDTH, `AXI_ADDR_WIDTH, address bits per request.
- DATA_WIDTH, `AXI_DATA_WIDTH, data bits per request.
- NUM_REQ, 4, number of requesters (2..16).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with lowest index highest.
- PW (localparam), ADDR_WIDTH+DATA_WIDTH, payload width.
- IW (localparam), max(1,$clog2(NUM_REQ)), grant index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_ready_o  out  NUM_REQ  per-requester ready (one-hot or zero).
- req_data_i  in  NUM_REQ*PW  payloads; requester i occupies bits [i*PW +: PW], each {addr,data}.
- fifo_afull_i  in  1  Fill FIFO almost-full.
- fifo_wren_o  out  1  Fill FIFO write enable.
- fifo_data_o  out  PW  Fill FIFO write data.
- grant_id_o  out  IW  index of the requester whose payload is in the output register.
- stall_cnt_o  out  32  count of cycles with the output register full and fifo_afull_i=1; saturates at 0xFFFFFFFF.

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately. On reset:
  - out_vld=0, fifo_data_o=0, grant_id_o=0, stall_cnt_o=0;
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority;
  - req_ready_o=0 and fifo_wren_o=0, since both are derived from out_vld and afull.
- Reset mid-operation drops any held entry, produces no write, and restarts arbitration from requester 0.
- Handshake: a transfer occurs when req_valid_i[i] & req_ready_o[i] are both high at a posedge. Requesters keep valid and data stable until the transfer. Withdrawing valid before transfer is illegal; the bench may flag it.
- Winner selection is combinational over req_valid_i:
  - MODE=0: first asserted index found scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - MODE=1: lowest asserted index.
- accept = (|req_valid_i) & !fifo_afull_i. req_ready_o = onehot(winner) when accept, else 0.
- Output register (out_vld, fifo_data_o, grant_id_o):
  - fifo_wren_o = out_vld & !fifo_afull_i (combinational).
  - On the clock edge:
    - if accept: load the winner payload and index, out_vld<=1;
    - else if fifo_wren_o: out_vld<=0;
    - else hold.
  - Simultaneous write and accept in one cycle is allowed: the old entry is written and the new entry loads. Sustained throughput is 1 request/cycle.
- Accept latency: payload appears on fifo_data_o the cycle after the transfer. fifo_wren_o rises in that same cycle if afull=0.
- Almost-full: no accepts and no writes while fifo_afull_i=1; the entry is held, and data and grant_id stay stable.
- rr_ptr <= winner, only on accept. Unaccepted requests never move the pointer.
- Fairness (MODE=0): with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ accepts.
- When out_vld=0, fifo_data_o=0 (cleared on the cycle out_vld falls).
- stall_cnt_o increments each cycle in which out_vld & fifo_afull_i.
- NUM_REQ=2 with MODE=0 reproduces alternating fill/rmiss priority.
- No $display in synthesisable code.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-transfer with out_vld=1 → all outputs 0 immediately; after release, requester 0 is served first.
- Single request, MODE=0, NUM_REQ=4: req_valid_i=4'b0100, data 0xA5 → req_ready_o=4'b0100 the same cycle; next cycle fifo_wren_o=1, fifo_data_o=0xA5, grant_id_o=2.
- All valid, held for 8 accepts, afull=0 → grant order 0,1,2,3,0,1,2,3; fifo_wren_o high for 8 consecutive cycles.
- MODE=1, all valid → requester 0 is granted every cycle; requesters 1..3 see no ready.
- fifo_afull_i=1 for 5 cycles with out_vld=1 → fifo_wren_o=0, req_ready_o=0, data held, stall_cnt_o +5. On deassert, one write occurs the same cycle and an accept of the pending request happens simultaneously.
- Random valid/afull with a scoreboard → every accepted payload is written exactly once in accept order, with no loss or duplication, and rr_ptr only advances on accept.

Source files
------------

// File: rtl/fill_arbiter_rr.sv
// fill_arbiter_rr: N-way round-robin / fixed-priority arbiter merging fill requests into the Fill FIFO write port.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
module fill_arbiter_rr #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int NUM_REQ = 4,
  parameter int MODE = 0,
  localparam int PW = ADDR_WIDTH + DATA_WIDTH,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*PW-1:0] req_data_i,
  input  logic                  fifo_afull_i,
  output logic                  fifo_wren_o,
  output logic [PW-1:0]         fifo_data_o,
  output logic [IW-1:0]         grant_id_o,
  output logic [31:0]           stall_cnt_o
);
  logic [IW-1:0] r_ptr, r_gid, w_win, w_idx;
  logic          r_vld, w_found, w_accept, w_wren;
  logic [PW-1:0] r_data;
  logic [31:0]   r_stall;
  // Scan starts just after the last winner in round-robin mode, at index 0 in fixed mode.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (MODE == 1) ? IW'(k) : IW'((int'(r_ptr) + k + 1) % NUM_REQ);
      if (!w_found && req_valid_i[w_idx]) begin
        w_win = w_idx;
        w_found = 1'b1;
      end
    end
  end
  assign w_accept = (|req_valid_i) & ~fifo_afull_i;
  assign w_wren = r_vld & ~fifo_afull_i;
  assign req_ready_o = w_accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win) : '0;
  assign fifo_wren_o = w_wren;
  assign fifo_data_o = r_data;
  assign grant_id_o = r_gid;
  assign stall_cnt_o = r_stall;
  // A write and a fresh accept may share a cycle: the load simply overwrites the drained entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_data <= '0;
      r_gid <= '0;
      r_ptr <= IW'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_vld <= 1'b1;
      r_data <= req_data_i[w_win*PW +: PW];
      r_gid <= w_win;
      r_ptr <= w_win;
    end else if (w_wren) begin
      r_vld <= 1'b0;
      r_data <= '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall <= '0;
    else if (r_vld && fifo_afull_i && !(&r_stall)) r_stall <= r_stall + 32'd1;
  end
endmodule

// File: tb/tb_fill_arbiter_rr.sv
// tb_fill_arbiter_rr: directed and scoreboarded checks of fill_arbiter_rr in round-robin and fixed-priority modes.
module tb_fill_arbiter_rr;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N = 4;
  localparam int PW = 16;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid_i = '0;
  logic [N*PW-1:0] req_data_i = '0;
  logic fifo_afull_i = 1'b0;
  logic [N-1:0] rdy0, rdy1;
  logic wren0, wren1;
  logic [PW-1:0] d0, d1;
  logic [IW-1:0] g0, g1;
  logic [31:0] s0, s1;
  logic [PW-1:0] pay [N];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  fill_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(rdy0),
    .req_data_i(req_data_i), .fifo_afull_i(fifo_afull_i), .fifo_wren_o(wren0),
    .fifo_data_o(d0), .grant_id_o(g0), .stall_cnt_o(s0));
  fill_arbiter_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(rdy1),
    .req_data_i(req_data_i), .fifo_afull_i(fifo_afull_i), .fifo_wren_o(wren1),
    .fifo_data_o(d1), .grant_id_o(g1), .stall_cnt_o(s1));
  task automatic set_pay();
    req_data_i = {pay[3], pay[2], pay[1], pay[0]};
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    req_valid_i = '0;
    fifo_afull_i = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_reset();
    #2;
    n_cmp++; if (wren0 !== 1'b0) begin n_err++; $display("FAIL reset_wren got %b want 0", wren0); end
    n_cmp++; if (d0 !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", d0); end
    n_cmp++; if (g0 !== '0) begin n_err++; $display("FAIL reset_gid got %0d want 0", g0); end
    n_cmp++; if (s0 !== '0) begin n_err++; $display("FAIL reset_stall got %0d want 0", s0); end
    n_cmp++; if (rdy0 !== '0) begin n_err++; $display("FAIL reset_ready got %b want 0", rdy0); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_single();
    do_reset();
    pay[2] = 16'h00A5;
    set_pay();
    req_valid_i = 4'b0100;
    #1;
    n_cmp++; if (rdy0 !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b want 0100", rdy0); end
    tick();
    req_valid_i = '0;
    #1;
    n_cmp++; if (wren0 !== 1'b1) begin n_err++; $display("FAIL single_wren got %b want 1", wren0); end
    n_cmp++; if (d0 !== 16'h00A5) begin n_err++; $display("FAIL single_data got %h want 00a5", d0); end
    n_cmp++; if (g0 !== 2'd2) begin n_err++; $display("FAIL single_gid got %0d want 2", g0); end
    tick();
    n_cmp++; if (wren0 !== 1'b0) begin n_err++; $display("FAIL single_drain_wren got %b want 0", wren0); end
    n_cmp++; if (d0 !== '0) begin n_err++; $display("FAIL single_drain_data got %h want 0", d0); end
  endtask
  task automatic test_all_valid();
    do_reset();
    for (int i = 0; i < N; i++) pay[i] = 16'h1000 + 16'(i);
    set_pay();
    req_valid_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++; if (rdy0 !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL rr_ready[%0d] got %b want %b", k, rdy0, 4'(1 << (k % 4))); end
      n_cmp++; if (rdy1 !== 4'b0001) begin n_err++; $display("FAIL fp_ready[%0d] got %b want 0001", k, rdy1); end
      if (k > 0) begin
        n_cmp++; if (wren0 !== 1'b1) begin n_err++; $display("FAIL rr_wren[%0d] got %b want 1", k, wren0); end
        n_cmp++; if (g0 !== 2'((k - 1) % 4)) begin n_err++; $display("FAIL rr_gid[%0d] got %0d want %0d", k, g0, (k - 1) % 4); end
        n_cmp++; if (d0 !== 16'h1000 + 16'((k - 1) % 4)) begin n_err++; $display("FAIL rr_data[%0d] got %h", k, d0); end
        n_cmp++; if (g1 !== 2'd0) begin n_err++; $display("FAIL fp_gid[%0d] got %0d want 0", k, g1); end
      end
      tick();
    end
    req_valid_i = '0;
    #1;
    n_cmp++; if (wren0 !== 1'b1) begin n_err++; $display("FAIL rr_last_wren got %b want 1", wren0); end
    n_cmp++; if (g0 !== 2'd3) begin n_err++; $display("FAIL rr_last_gid got %0d want 3", g0); end
    n_cmp++; if (d0 !== 16'h1003) begin n_err++; $display("FAIL rr_last_data got %h want 1003", d0); end
    tick();
    n_cmp++; if (wren0 !== 1'b0) begin n_err++; $display("FAIL rr_idle_wren got %b want 0", wren0); end
  endtask
  task automatic test_afull();
    do_reset();
    for (int i = 0; i < N; i++) pay[i] = 16'h1000 + 16'(i);
    set_pay();
    req_valid_i = 4'b1111;
    #1;
    n_cmp++; if (rdy0 !== 4'b0001) begin n_err++; $display("FAIL afull_first_ready got %b want 0001", rdy0); end
    tick();
    fifo_afull_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (wren0 !== 1'b0) begin n_err++; $display("FAIL afull_wren[%0d] got %b want 0", c, wren0); end
      n_cmp++; if (rdy0 !== 4'b0000) begin n_err++; $display("FAIL afull_ready[%0d] got %b want 0000", c, rdy0); end
      n_cmp++; if (d0 !== 16'h1000) begin n_err++; $display("FAIL afull_data[%0d] got %h want 1000", c, d0); end
      n_cmp++; if (s0 !== 32'(c)) begin n_err++; $display("FAIL afull_stall[%0d] got %0d want %0d", c, s0, c); end
      tick();
    end
    n_cmp++; if (s0 !== 32'd5) begin n_err++; $display("FAIL afull_stall_total got %0d want 5", s0); end
    fifo_afull_i = 1'b0;
    #1;
    n_cmp++; if (wren0 !== 1'b1) begin n_err++; $display("FAIL afull_release_wren got %b want 1", wren0); end
    n_cmp++; if (rdy0 !== 4'b0010) begin n_err++; $display("FAIL afull_release_ready got %b want 0010", rdy0); end
    tick();
    n_cmp++; if (d0 !== 16'h1001) begin n_err++; $display("FAIL afull_next_data got %h want 1001", d0); end
    n_cmp++; if (g0 !== 2'd1) begin n_err++; $display("FAIL afull_next_gid got %0d want 1", g0); end
    n_cmp++; if (s0 !== 32'd5) begin n_err++; $display("FAIL afull_stall_hold got %0d want 5", s0); end
  endtask
  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    req_valid_i = '0;
    #1;
    n_cmp++; if (wren0 !== 1'b0) begin n_err++; $display("FAIL mid_reset_wren got %b want 0", wren0); end
    n_cmp++; if (d0 !== '0) begin n_err++; $display("FAIL mid_reset_data got %h want 0", d0); end
    n_cmp++; if (g0 !== '0) begin n_err++; $display("FAIL mid_reset_gid got %0d want 0", g0); end
    n_cmp++; if (s0 !== '0) begin n_err++; $display("FAIL mid_reset_stall got %0d want 0", s0); end
    tick();
    rst_n = 1'b1;
    req_valid_i = 4'b1111;
    #1;
    n_cmp++; if (rdy0 !== 4'b0001) begin n_err++; $display("FAIL mid_reset_first_ready got %b want 0001", rdy0); end
    tick();
    req_valid_i = 4'b1110;
    #1;
    n_cmp++; if (g0 !== 2'd0) begin n_err++; $display("FAIL mid_reset_first_gid got %0d want 0", g0); end
    n_cmp++; if (d0 !== pay[0]) begin n_err++; $display("FAIL mid_reset_first_data got %h want %h", d0, pay[0]); end
    req_valid_i = '0;
    tick();
  endtask
  task automatic test_random();
    logic [PW-1:0] q[$];
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic exp_w;
    int mptr;
    int acc;
    int win;
    do_reset();
    v = '0;
    mptr = N - 1;
    acc = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (acc >= 0) v[acc] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(2) == 0) begin
          v[i] = 1'b1;
          pay[i] = PW'($urandom);
        end
      set_pay();
      req_valid_i = v;
      fifo_afull_i = ($urandom_range(3) == 0);
      #1;
      win = -1;
      exp_rdy = '0;
      if (v != '0 && !fifo_afull_i)
        for (int k = 1; k <= N; k++)
          if (win < 0 && v[(mptr + k) % N]) win = (mptr + k) % N;
      if (win >= 0) exp_rdy[win] = 1'b1;
      exp_w = (q.size() != 0) && !fifo_afull_i;
      n_cmp++; if (rdy0 !== exp_rdy) begin n_err++; $display("FAIL rand_ready[%0d] got %b want %b", cyc, rdy0, exp_rdy); end
      n_cmp++; if (wren0 !== exp_w) begin n_err++; $display("FAIL rand_wren[%0d] got %b want %b", cyc, wren0, exp_w); end
      if (exp_w) begin
        n_cmp++; if (d0 !== q[0]) begin n_err++; $display("FAIL rand_data[%0d] got %h want %h", cyc, d0, q[0]); end
        void'(q.pop_front());
      end
      if (win >= 0) begin
        q.push_back(pay[win]);
        mptr = win;
      end
      acc = win;
      tick();
    end
    req_valid_i = '0;
    fifo_afull_i = 1'b0;
    #1;
    if (q.size() != 0) begin
      n_cmp++; if (wren0 !== 1'b1 || d0 !== q[0]) begin n_err++; $display("FAIL rand_drain got wren=%b data=%h want 1/%h", wren0, d0, q[0]); end
      void'(q.pop_front());
    end
    tick();
    n_cmp++; if (wren0 !== 1'b0) begin n_err++; $display("FAIL rand_empty_wren got %b want 0", wren0); end
  endtask
  initial begin
    for (int i = 0; i < N; i++) pay[i] = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_afull();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
